cnt_seq_decoder: RTL and testbench
==================================

Name: cnt_seq_decoder

Overview:
Observer for the up/down step counter. It samples the counter's output value stream and recovers the counting mode: direction (down) and step size (step, 0 means 1, 1 means 2). It locks once the mode has been consistent long enough, and flags any sample that breaks the locked sequence. It sits on the counter's output bus as the checker/reader end of the counter interface.

Parameters:
WIDTH, 4, width of the sampled counter value; legal range WIDTH >= 3 (for WIDTH = 2, +2 and -2 alias).
LOCK_CNT, 3, number of consecutive identical-mode deltas required to assert locked; legal range 1..15.
ERRW, 8, width of the saturating error counter.

Ports:
clk  in  1  clock, rising-edge.
nrst  in  1  asynchronous active-low reset.
valid  in  1  sample strobe; value is consumed on a rising clk edge while valid=1.
value  in  WIDTH  counter output being observed.
locked  out  1  mode recovered and stable.
down  out  1  recovered direction; 1 means counting down; meaningful only while locked=1.
step  out  1  recovered step; 1 means step 2, 0 means step 1; meaningful only while locked=1.
err  out  1  one-cycle pulse: a locked sequence was broken.
err_cnt  out  ERRW  saturating count of err pulses since reset.

Behaviour:
- Reset (nrst=0, asynchronous, no clock needed): state=IDLE, prev=0, cand=0, match=0, locked=0, down=0, step=0, err=0, err_cnt=0. Reset asserted mid-operation clears everything immediately and discards any partial lock.
- All outputs are registered and update on the edge that consumes a valid sample; the result is visible in the following cycle.
- valid=0: all state holds; err is driven 0 on that edge.
- Delta: d = (value - prev) mod 2^WIDTH. Classification:
  - d = 1 → UP1 {down=0, step=0}
  - d = 2 → UP2 {0, 1}
  - d = 2^WIDTH-1 → DN1 {1, 0}
  - d = 2^WIDTH-2 → DN2 {1, 1}
  - any other d, including 0 → BAD.
  - Wrap-around is natural (WIDTH=4: 15→0 is UP1; 0→14 is DN2).
- prev is loaded with value on every consumed sample, in every state.
- States:
  - IDLE: first valid sample loads prev only → ACQ, match=0.
  - ACQ, class valid and (match=0 or class=cand): cand=class, match+1. When match reaches LOCK_CNT → LOCKED; locked=1, {down, step}=cand on that same edge.
  - ACQ, class valid and class≠cand (match>0): cand=class, match=1.
  - ACQ, class BAD: match=0.
  - LOCKED, class=cand: stay; no output change.
  - LOCKED, class≠cand (including BAD): err=1 for exactly one cycle; err_cnt+1, saturating at 2^ERRW-1; locked=0; down/step hold their last values → ACQ with cand=class and match=1 if class is valid, else match=0.
- An err pulse always clears on the next edge, whether or not valid is high.
- The match counter is sized ceil(log2(LOCK_CNT+1)) bits and never exceeds LOCK_CNT.

Optional Feature:
CNT_SEQ_HOLD_EN. When defined, d=0 (counter stalled, e.g. clock-gated source) is HOLD, not BAD. HOLD is neutral in every state: no match increment, no match clear, no err. When undefined, d=0 is BAD as specified above.

Test Plan:
- Reset, LOCK_CNT=3, valid samples 14,15,0,1 → locked rises after the sample 1 edge; down=0, step=0; err never asserts.
- Reset, samples 3,1,15,13 → locked=1, down=1, step=1 after the 13 edge.
- Locked on UP1 (…,4,5), then sample 9 → err=1 for one cycle, locked=0, err_cnt=1; then 10,11,12 → relocks (match starts at 0 because 5→9 is BAD); err_cnt stays 1.
- Locked UP2, valid held low for 5 cycles between samples 6 and 8 → no state change, locked stays 1, err stays 0.
- ERRW=2, five lock/break cycles → err_cnt reads 1,2,3,3,3.
- Locked, nrst pulsed low between clock edges → all outputs 0 before the next edge. With CNT_SEQ_HOLD_EN defined, locked UP1 sequence 7,7,8 → no err, locked stays 1. Without it, the same sequence → err=1.

Source files
------------

// File: rtl/cnt_seq_decoder.sv
// Observer for an up/down step counter: recovers direction and step size from the sampled value stream.
// Optional build macro CNT_SEQ_HOLD_EN: a zero delta (stalled counter) is neutral instead of breaking the sequence.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// S_IDLE   | no reference sample yet; next valid sample only loads prev
// S_ACQ    | counting consecutive identical-mode deltas toward lock
// S_LOCKED | mode recovered; any differing delta raises err and re-acquires
module cnt_seq_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             valid,
  input  logic [WIDTH-1:0] value,
  output logic             locked,
  output logic             down,
  output logic             step,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW:0]      NM_ONE   = (MW+1)'(1);
  localparam logic [MW:0]      NM_LOCK  = (MW+1)'(LOCK_CNT);
  localparam logic [MW-1:0]    M_LOCK   = MW'(LOCK_CNT);
  localparam logic [ERRW-1:0]  CNT_ONE  = ERRW'(1);
  localparam logic [WIDTH-1:0] D_UP1    = WIDTH'(1);
  localparam logic [WIDTH-1:0] D_UP2    = WIDTH'(2);
  localparam logic [WIDTH-1:0] D_DN1    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] D_DN2    = ~WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_cand;   // {down, step} of the candidate mode
  logic [MW-1:0]    r_match;
  logic             r_locked;
  logic             r_down;
  logic             r_step;
  logic             r_err;
  logic [ERRW-1:0]  r_err_cnt;

  logic [WIDTH-1:0] w_delta;
  logic             w_ok;
  logic             w_hold;
  logic [1:0]       w_cls;
  logic             w_same;
  logic [MW:0]      w_nm;
  logic             w_lock;

  assign w_delta = value - r_prev;

  always_comb begin
    w_ok  = 1'b1;
    w_cls = 2'b00;
    if (w_delta == D_UP1)      w_cls = 2'b00;
    else if (w_delta == D_UP2) w_cls = 2'b01;
    else if (w_delta == D_DN1) w_cls = 2'b10;
    else if (w_delta == D_DN2) w_cls = 2'b11;
    else                       w_ok  = 1'b0;
  end

`ifdef CNT_SEQ_HOLD_EN
  assign w_hold = (w_delta == '0);
`else
  assign w_hold = 1'b0;
`endif

  assign w_same = w_ok && (w_cls == r_cand);

  // A mode change restarts the run at one; the run saturates at LOCK_CNT.
  always_comb begin
    if (r_match == '0 || w_same) w_nm = {1'b0, r_match} + NM_ONE;
    else                         w_nm = NM_ONE;
  end
  assign w_lock = (w_nm >= NM_LOCK);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_cand    <= '0;
      r_match   <= '0;
      r_locked  <= 1'b0;
      r_down    <= 1'b0;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid) begin
        r_prev <= value;
        case (r_state)
          S_IDLE: begin
            r_state <= S_ACQ;
            r_match <= '0;
          end
          S_ACQ: begin
            if (w_hold) begin
              r_match <= r_match;
            end else if (!w_ok) begin
              r_match <= '0;
            end else begin
              r_cand <= w_cls;
              if (w_lock) begin
                r_match  <= M_LOCK;
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
                r_down   <= w_cls[1];
                r_step   <= w_cls[0];
              end else begin
                r_match <= w_nm[MW-1:0];
              end
            end
          end
          S_LOCKED: begin
            if (!w_hold && !w_same) begin
              r_err    <= 1'b1;
              r_locked <= 1'b0;
              r_state  <= S_ACQ;
              if (r_err_cnt != {ERRW{1'b1}}) r_err_cnt <= r_err_cnt + CNT_ONE;
              if (w_ok) begin
                r_cand  <= w_cls;
                r_match <= MW'(1);
              end else begin
                r_match <= '0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign locked  = r_locked;
  assign down    = r_down;
  assign step    = r_step;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_cnt_seq_decoder.sv
// Bench for cnt_seq_decoder: vector table, hand-written corner sequences, and random stimulus against a reference model.
// Honours CNT_SEQ_HOLD_EN the same way the design does.
module tb_cnt_seq_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int M        = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             nrst;
  logic             valid;
  logic [WIDTH-1:0] value;
  logic             locked, down, step, err;
  logic [7:0]       err_cnt;
  logic             locked2, down2, step2, err2;
  logic [1:0]       err_cnt2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cnt_seq_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(8)) dut (
    .clk(clk), .nrst(nrst), .valid(valid), .value(value),
    .locked(locked), .down(down), .step(step), .err(err), .err_cnt(err_cnt));

  cnt_seq_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(2)) dut2 (
    .clk(clk), .nrst(nrst), .valid(valid), .value(value),
    .locked(locked2), .down(down2), .step(step2), .err(err2), .err_cnt(err_cnt2));

`ifdef CNT_SEQ_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // Reference model: mode codes 0..3 = down*2+step, -1 = bad delta, -2 = neutral stall.
  int m_phase, m_prev, m_cand, m_run, m_cnt;
  bit m_locked, m_down, m_step, m_err;

  function automatic int mode_of(int v, int p);
    int d;
    d = (v - p) & (M - 1);
    if (d == 1)     return 0;
    if (d == 2)     return 1;
    if (d == M - 1) return 2;
    if (d == M - 2) return 3;
    if (d == 0 && HOLD) return -2;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_prev = 0; m_cand = 0; m_run = 0; m_cnt = 0;
    m_locked = 0; m_down = 0; m_step = 0; m_err = 0;
  endtask

  task automatic model_edge(bit v, int val);
    int c;
    m_err = 0;
    if (!v) return;
    c = mode_of(val, m_prev);
    m_prev = val;
    if (m_phase == 0) begin
      m_phase = 1; m_run = 0;
    end else if (c == -2) begin
    end else if (m_phase == 1) begin
      if (c < 0) m_run = 0;
      else begin
        m_run = (m_run == 0 || c == m_cand) ? m_run + 1 : 1;
        m_cand = c;
        if (m_run >= LOCK_CNT) begin
          m_run = LOCK_CNT; m_phase = 2; m_locked = 1;
          m_down = (c >= 2); m_step = (c % 2 == 1);
        end
      end
    end else if (c != m_cand) begin
      m_err = 1; m_locked = 0; m_phase = 1;
      if (m_cnt < 255) m_cnt++;
      if (c >= 0) begin m_cand = c; m_run = 1; end
      else m_run = 0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit v, int val);
    @(negedge clk);
    valid = v;
    value = WIDTH'(val);
    @(posedge clk);
    model_edge(v, val);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0; valid = 0; value = '0;
    model_reset();
    @(negedge clk);
    nrst = 1;
  endtask

  function automatic logic [3:0] flags();
    return {locked, down, step, err};
  endfunction

  typedef struct {
    bit         vld;
    int         val;
    logic [3:0] fl;    // {locked, down, step, err}
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } vec_t;

  vec_t vt[20];

  initial begin
    int gen_val, gen_mode, dl;
    bit rv;

    vt[0]  = '{1, 14, 4'b0000, 0, 0};
    vt[1]  = '{1, 15, 4'b0000, 0, 0};
    vt[2]  = '{1,  0, 4'b0000, 0, 0};
    vt[3]  = '{1,  1, 4'b1000, 0, 0};
    vt[4]  = '{1,  2, 4'b1000, 0, 0};
    vt[5]  = '{1,  3, 4'b1000, 0, 0};
    vt[6]  = '{1,  7, 4'b0001, 1, 1};
    vt[7]  = '{1,  8, 4'b0000, 1, 1};
    vt[8]  = '{1,  9, 4'b0000, 1, 1};
    vt[9]  = '{1, 10, 4'b1000, 1, 1};
    vt[10] = '{1,  8, 4'b0001, 2, 2};
    vt[11] = '{1,  6, 4'b0000, 2, 2};
    vt[12] = '{1,  4, 4'b1110, 2, 2};
    vt[13] = '{0,  9, 4'b1110, 2, 2};
    vt[14] = '{1,  2, 4'b1110, 2, 2};
    vt[15] = '{1,  1, 4'b0111, 3, 3};
    vt[16] = '{1,  0, 4'b0110, 3, 3};
    vt[17] = '{1, 15, 4'b1100, 3, 3};
    if (HOLD) begin
      vt[18] = '{1, 15, 4'b1100, 3, 3};
      vt[19] = '{0, 15, 4'b1100, 3, 3};
    end else begin
      vt[18] = '{1, 15, 4'b0101, 4, 3};
      vt[19] = '{0, 15, 4'b0100, 4, 3};
    end

    nrst = 0; valid = 0; value = '0;
    model_reset();
    #2;
    chk("reset_flags", flags(), 4'b0000);
    chk("reset_cnt", err_cnt, 0);
    do_reset();

    foreach (vt[i]) begin
      cyc(vt[i].vld, vt[i].val);
      chk($sformatf("vec%0d_flags", i), flags(), vt[i].fl);
      chk($sformatf("vec%0d_cnt", i), err_cnt, vt[i].cnt);
      chk($sformatf("vec%0d_cnt2", i), err_cnt2, vt[i].cnt2);
    end

    // DN2 lock from 3,1,15,13 then asynchronous reset between edges
    do_reset();
    cyc(1, 3); cyc(1, 1); cyc(1, 15);
    chk("dn2_prelock", flags(), 4'b0000);
    cyc(1, 13);
    chk("dn2_lock", flags(), 4'b1110);
    #2 nrst = 0;
    #1;
    chk("async_rst_flags", flags(), 4'b0000);
    chk("async_rst_flags2", {locked2, down2, step2, err2}, 4'b0000);
    chk("async_rst_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk) nrst = 1;
    cyc(1, 5);
    chk("post_rst_idle", flags(), 4'b0000);

    // UP2 lock with valid low for five cycles between 6 and 8
    do_reset();
    cyc(1, 0); cyc(1, 2); cyc(1, 4); cyc(1, 6);
    chk("up2_lock", flags(), 4'b1010);
    for (int k = 0; k < 5; k++) begin
      cyc(0, $urandom_range(0, 15));
      chk("up2_gap", flags(), 4'b1010);
    end
    cyc(1, 8);
    chk("up2_resume", flags(), 4'b1010);
    chk("up2_cnt", err_cnt, 0);

    // Break then relock: 5->9 is bad so the run restarts from zero
    do_reset();
    cyc(1, 2); cyc(1, 3); cyc(1, 4); cyc(1, 5);
    chk("up1_lock", flags(), 4'b1000);
    cyc(1, 9);
    chk("break_err", flags(), 4'b0001);
    chk("break_cnt", err_cnt, 1);
    cyc(1, 10);
    chk("relock_1", flags(), 4'b0000);
    cyc(1, 11);
    chk("relock_2", flags(), 4'b0000);
    cyc(1, 12);
    chk("relock_3", flags(), 4'b1000);
    chk("relock_cnt", err_cnt, 1);

    // Stall 7,7,8 on a locked UP1 sequence
    do_reset();
    cyc(1, 4); cyc(1, 5); cyc(1, 6); cyc(1, 7);
    cyc(1, 7);
    chk("stall_err", err, HOLD ? 1'b0 : 1'b1);
    cyc(1, 8);
    chk("stall_after", flags(), HOLD ? 4'b1000 : 4'b0000);

    // Random stimulus against the reference model
    do_reset();
    gen_val = $urandom_range(0, M - 1);
    gen_mode = $urandom_range(0, 3);
    for (int n = 0; n < 600; n++) begin
      int r;
      rv = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 24);
      if (r == 0) gen_mode = $urandom_range(0, 3);
      if (r == 1) gen_val = $urandom_range(0, M - 1);
      else if (r != 2) begin
        dl = (gen_mode == 0) ? 1 : (gen_mode == 1) ? 2 : (gen_mode == 2) ? -1 : -2;
        gen_val = (gen_val + dl) & (M - 1);
      end
      cyc(rv, gen_val);
      chk("rand_flags", flags(), {m_locked, m_down, m_step, m_err});
      chk("rand_cnt", err_cnt, m_cnt);
      chk("rand_cnt2", err_cnt2, (m_cnt > 3) ? 3 : m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
